// File: rtl/random_spawn_sched.sv
// random_spawn_sched: requests a random sample from the generator, clamps it,
// maps it to a spawn X pixel, and offers it to the spawner over valid/ready.
// Requests are paced in video frames.
// Optional feature macro: NO_REPEAT_EN. When it is defined, a sample equal to
// the last accepted value is re-requested. After MAX_RETRY attempts the value
// is bumped by one instead.

module random_spawn_sched #(
    parameter int SIZE_BITS  = 5,
    parameter int MIN_VAL    = 0,
    parameter int MAX_VAL    = 12,
    parameter int X_BASE     = 320,
    parameter int X_STEP     = 24,
    parameter int X_LIMIT    = 639,
    parameter int GAP_FRAMES = 4
`ifdef NO_REPEAT_EN
    ,
    parameter int MAX_RETRY  = 3
`endif
) (
    input  logic                 clk_i,
    input  logic                 resetN_i,
    input  logic                 enable_i,
    input  logic                 startOfFrame_i,
    input  logic [SIZE_BITS-1:0] rnd_in_i,
    output logic                 rise_req_o,
    output logic                 spawn_valid_o,
    input  logic                 spawn_ready_i,
    output logic [10:0]          spawn_x_o,
    output logic [7:0]           spawn_count_o,
    output logic                 busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_CAP,
        ST_MAP,
        ST_OFFER,
        ST_GAP
`ifdef NO_REPEAT_EN
        ,
        ST_REST
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             gap_q, gap_d;
    logic [SIZE_BITS-1:0]   val_q, val_d;
    logic                   rise_req_q, rise_req_d;
    logic                   spawn_valid_q, spawn_valid_d;
    logic [10:0]            spawn_x_q, spawn_x_d;
    logic [7:0]             spawn_count_q, spawn_count_d;
    logic                   busy_q, busy_d;

`ifdef NO_REPEAT_EN
    logic [7:0]             retry_q, retry_d;
    logic [SIZE_BITS-1:0]   last_q, last_d;
    logic                   lastValid_q, lastValid_d;
    logic [SIZE_BITS-1:0]   bumpVal;
`endif

    int                     sampleInt;
    logic [SIZE_BITS-1:0]   clampVal;
    logic [15:0]            xWide;
    logic [10:0]            xSat;
    logic                   accept;

    assign accept = spawn_valid_q & spawn_ready_i;

    // Clamp the generator sample into the legal [MIN_VAL, MAX_VAL] range
    always_comb begin
        sampleInt = int'(rnd_in_i);
        if (sampleInt > MAX_VAL) begin
            clampVal = SIZE_BITS'(MAX_VAL);
        end else if (sampleInt < MIN_VAL) begin
            clampVal = SIZE_BITS'(MIN_VAL);
        end else begin
            clampVal = rnd_in_i;
        end
`ifdef NO_REPEAT_EN
        bumpVal = (clampVal == SIZE_BITS'(MAX_VAL)) ? SIZE_BITS'(MIN_VAL)
                                                    : clampVal + SIZE_BITS'(1);
`endif
    end

    // Map the captured value to a pixel column and saturate at the screen edge
    always_comb begin
        xWide = 16'(X_BASE) + 16'(int'(val_q) - MIN_VAL) * 16'(X_STEP);
        xSat  = (xWide > 16'(X_LIMIT)) ? 11'(X_LIMIT) : xWide[10:0];
    end

    // State and datapath registers, all cleared by the asynchronous reset
    always_ff @(posedge clk_i or negedge resetN_i) begin
        if (!resetN_i) begin
            state_q       <= ST_IDLE;
            gap_q         <= '0;
            val_q         <= '0;
            rise_req_q    <= 1'b0;
            spawn_valid_q <= 1'b0;
            spawn_x_q     <= '0;
            spawn_count_q <= '0;
            busy_q        <= 1'b0;
`ifdef NO_REPEAT_EN
            retry_q       <= '0;
            last_q        <= '0;
            lastValid_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            gap_q         <= gap_d;
            val_q         <= val_d;
            rise_req_q    <= rise_req_d;
            spawn_valid_q <= spawn_valid_d;
            spawn_x_q     <= spawn_x_d;
            spawn_count_q <= spawn_count_d;
            busy_q        <= busy_d;
`ifdef NO_REPEAT_EN
            retry_q       <= retry_d;
            last_q        <= last_d;
            lastValid_q   <= lastValid_d;
`endif
        end
    end

    // Next-state logic; enable low aborts every state except an open offer
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        val_d   = val_q;
`ifdef NO_REPEAT_EN
        retry_d     = retry_q;
        last_d      = last_q;
        lastValid_d = lastValid_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (enable_i) state_d = ST_REQ;
            end
            ST_REQ: begin
                state_d = enable_i ? ST_CAP : ST_IDLE;
            end
            ST_CAP: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else begin
                    val_d   = clampVal;
                    state_d = ST_MAP;
`ifdef NO_REPEAT_EN
                    if (lastValid_q && (clampVal == last_q)) begin
                        if (retry_q < 8'(MAX_RETRY)) begin
                            retry_d = retry_q + 8'd1;
                            state_d = ST_REST;
                        end else begin
                            val_d = bumpVal;
                        end
                    end
                    if (state_d == ST_MAP) retry_d = '0;
`endif
                end
            end
`ifdef NO_REPEAT_EN
            ST_REST: begin
                state_d = enable_i ? ST_REQ : ST_IDLE;
            end
`endif
            ST_MAP: begin
                state_d = enable_i ? ST_OFFER : ST_IDLE;
            end
            ST_OFFER: begin
                if (accept) begin
                    gap_d   = 8'(GAP_FRAMES);
                    state_d = enable_i ? ST_GAP : ST_IDLE;
`ifdef NO_REPEAT_EN
                    last_d      = val_q;
                    lastValid_d = 1'b1;
`endif
                end
            end
            ST_GAP: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (gap_q == 8'd0) begin
                    state_d = ST_REQ;
                end else if (startOfFrame_i) begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs derived from the upcoming state
    always_comb begin
        rise_req_d    = (state_d == ST_REQ);
        spawn_valid_d = (state_d == ST_OFFER);
        busy_d        = (state_d != ST_IDLE);
        spawn_x_d     = spawn_x_q;
        spawn_count_d = spawn_count_q;
        if ((state_q == ST_MAP) && (state_d == ST_OFFER)) spawn_x_d = xSat;
        if ((state_q == ST_OFFER) && accept) spawn_count_d = spawn_count_q + 8'd1;
    end

    assign rise_req_o    = rise_req_q;
    assign spawn_valid_o = spawn_valid_q;
    assign spawn_x_o     = spawn_x_q;
    assign spawn_count_o = spawn_count_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_random_spawn_sched.sv
// Bench for random_spawn_sched. A default instance (X_STEP=24) and a second
// instance (X_STEP=40) share the same stimulus. Expected spawn X values are
// pushed to queues when a request is set up and popped at each handshake.
// The NO_REPEAT_EN scenario is compiled only when that macro is defined.

module tb_random_spawn_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetN = 1'b0, enable = 1'b0, startOfFrame = 1'b0, spawnReady = 1'b0;
    logic [4:0]  rndIn = '0, nextRnd = '0;
    logic        riseReq, spawnValid, busy, riseReq2, spawnValid2, busy2;
    logic [10:0] spawnX, spawnX2;
    logic [7:0]  spawnCount, spawnCount2;

    int riseCount = 0, doubleRise = 0;
    logic riseReqPrev = 1'b0;
    int compared = 0, mismatched = 0, expCount = 0;
    int expQ[$], exp2Q[$];

    random_spawn_sched dut (
        .clk_i(clk), .resetN_i(resetN), .enable_i(enable), .startOfFrame_i(startOfFrame),
        .rnd_in_i(rndIn), .rise_req_o(riseReq), .spawn_valid_o(spawnValid),
        .spawn_ready_i(spawnReady), .spawn_x_o(spawnX), .spawn_count_o(spawnCount), .busy_o(busy)
    );

    random_spawn_sched #(.X_STEP(40)) dut2 (
        .clk_i(clk), .resetN_i(resetN), .enable_i(enable), .startOfFrame_i(startOfFrame),
        .rnd_in_i(rndIn), .rise_req_o(riseReq2), .spawn_valid_o(spawnValid2),
        .spawn_ready_i(spawnReady), .spawn_x_o(spawnX2), .spawn_count_o(spawnCount2), .busy_o(busy2)
    );

    // Generator model: a new value appears on the edge where the request is seen
    always @(posedge clk) if (riseReq) rndIn <= nextRnd;

    // Request monitor: counts request pulses and back-to-back high cycles
    always @(posedge clk) begin
        if (riseReq && riseReqPrev) doubleRise <= doubleRise + 1;
        if (riseReq) riseCount <= riseCount + 1;
        riseReqPrev <= riseReq;
    end

    function automatic int clampModel(input int rnd);
        return (rnd > 12) ? 12 : rnd;
    endfunction

    function automatic int modelX(input int v, input int step);
        int x;
        x = 320 + clampModel(v) * step;
        return (x > 639) ? 639 : x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        resetN = 1'b0; enable = 1'b0; startOfFrame = 1'b0; spawnReady = 1'b0;
        repeat (2) tick();
        resetN = 1'b1;
        tick();
        expCount = 0;
        expQ.delete();
        exp2Q.delete();
    endtask

    // Sets up a request and waits (bounded) for the offer; frame ticks can be auto-generated
    task automatic startOffer(input int rnd, input int e1, input int e2, input bit autoFrames);
        bit ok;
        nextRnd = 5'(rnd);
        expQ.push_back(e1);
        exp2Q.push_back(e2);
        enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (spawnValid === 1'b1) begin ok = 1'b1; break; end
            startOfFrame = autoFrames && (i % 2 == 0);
            tick();
        end
        startOfFrame = 1'b0;
        compared++;
        if (!ok) begin
            mismatched++;
            $display("[TB] FAIL offer_timeout: spawn_valid got %b expected 1 within 80 cycles", spawnValid);
        end
    endtask

    // Pops the scoreboard, checks both X values, then completes the handshake
    task automatic acceptOffer();
        int e1, e2;
        e1 = (expQ.size() > 0) ? expQ.pop_front() : -1;
        e2 = (exp2Q.size() > 0) ? exp2Q.pop_front() : -1;
        compared += 2;
        if (int'(spawnX) !== e1) begin
            mismatched++;
            $display("[TB] FAIL spawn_x: got %0d expected %0d", spawnX, e1);
        end
        if (int'(spawnX2) !== e2) begin
            mismatched++;
            $display("[TB] FAIL spawn_x_step40: got %0d expected %0d", spawnX2, e2);
        end
        spawnReady = 1'b1;
        tick();
        spawnReady = 1'b0;
        expCount = (expCount + 1) % 256;
        compared += 3;
        if (spawnValid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL valid_drop: got %b expected 0", spawnValid);
        end
        if (spawnCount !== 8'(expCount)) begin
            mismatched++;
            $display("[TB] FAIL spawn_count: got %0d expected %0d", spawnCount, expCount);
        end
        if (spawnCount2 !== 8'(expCount)) begin
            mismatched++;
            $display("[TB] FAIL spawn_count_step40: got %0d expected %0d", spawnCount2, expCount);
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (2) tick();
        compared += 5;
        if (riseReq !== 1'b0)     begin mismatched++; $display("[TB] FAIL reset_rise: got %b expected 0", riseReq); end
        if (spawnValid !== 1'b0)  begin mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", spawnValid); end
        if (spawnX !== 11'd0)     begin mismatched++; $display("[TB] FAIL reset_x: got %0d expected 0", spawnX); end
        if (spawnCount !== 8'd0)  begin mismatched++; $display("[TB] FAIL reset_count: got %0d expected 0", spawnCount); end
        if (busy !== 1'b0)        begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        resetN = 1'b1;
        spawnReady = 1'b1;
        repeat (3) tick();
        spawnReady = 1'b0;
        compared += 2;
        if (spawnCount !== 8'd0)  begin mismatched++; $display("[TB] FAIL ready_ignored: got %0d expected 0", spawnCount); end
        if (busy !== 1'b0)        begin mismatched++; $display("[TB] FAIL idle_disabled: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        applyReset();
        nextRnd = 5'd7;
        expQ.push_back(modelX(7, 24));
        exp2Q.push_back(modelX(7, 40));
        enable = 1'b1;
        tick();
        compared += 2;
        if (riseReq !== 1'b1)  begin mismatched++; $display("[TB] FAIL rise_pulse: got %b expected 1", riseReq); end
        if (riseReq2 !== 1'b1) begin mismatched++; $display("[TB] FAIL rise_pulse_step40: got %b expected 1", riseReq2); end
        tick();
        compared += 2;
        if (riseReq !== 1'b0)    begin mismatched++; $display("[TB] FAIL rise_single: got %b expected 0", riseReq); end
        if (spawnValid !== 1'b0) begin mismatched++; $display("[TB] FAIL valid_early_cap: got %b expected 0", spawnValid); end
        tick();
        compared++;
        if (spawnValid !== 1'b0) begin mismatched++; $display("[TB] FAIL valid_early_map: got %b expected 0", spawnValid); end
        tick();
        compared += 2;
        if (spawnValid !== 1'b1)  begin mismatched++; $display("[TB] FAIL valid_latency: got %b expected 1", spawnValid); end
        if (spawnValid2 !== 1'b1) begin mismatched++; $display("[TB] FAIL valid_latency_step40: got %b expected 1", spawnValid2); end
        acceptOffer();
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL busy_in_gap: got %b expected 1", busy); end
    endtask

    task automatic test_clamp();
        applyReset();
        startOffer(31, modelX(31, 24), modelX(31, 40), 1'b1);
        acceptOffer();
        applyReset();
        startOffer(12, modelX(12, 24), modelX(12, 40), 1'b1);
        acceptOffer();
        applyReset();
        startOffer(0, modelX(0, 24), modelX(0, 40), 1'b1);
        acceptOffer();
    endtask

    task automatic test_hold_and_gap();
        int r0;
        applyReset();
        startOffer(9, modelX(9, 24), modelX(9, 40), 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            compared += 2;
            if (spawnValid !== 1'b1) begin mismatched++; $display("[TB] FAIL hold_valid: got %b expected 1", spawnValid); end
            if (int'(spawnX) !== expQ[0]) begin mismatched++; $display("[TB] FAIL hold_x: got %0d expected %0d", spawnX, expQ[0]); end
        end
        compared++;
        if (spawnCount !== 8'd0) begin mismatched++; $display("[TB] FAIL hold_count: got %0d expected 0", spawnCount); end
        acceptOffer();
        r0 = riseCount;
        for (int f = 0; f < 3; f++) begin
            startOfFrame = 1'b1; tick(); startOfFrame = 1'b0; repeat (2) tick();
        end
        repeat (5) tick();
        compared++;
        if (riseCount !== r0) begin mismatched++; $display("[TB] FAIL gap_early_req: got %0d requests expected 0", riseCount - r0); end
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (riseReq === 1'b1) break;
            tick();
        end
        compared++;
        if (riseReq !== 1'b1) begin mismatched++; $display("[TB] FAIL gap_req_after_frames: got %b expected 1", riseReq); end
    endtask

    task automatic test_enable_drop();
        int r0;
        applyReset();
        startOffer(3, modelX(3, 24), modelX(3, 40), 1'b1);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++;
            if (spawnValid !== 1'b1) begin mismatched++; $display("[TB] FAIL offer_survives_disable: got %b expected 1", spawnValid); end
        end
        acceptOffer();
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL offer_then_idle: got %b expected 0", busy); end
        startOffer(4, modelX(4, 24), modelX(4, 40), 1'b1);
        acceptOffer();
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0; tick();
        enable = 1'b0;
        repeat (2) tick();
        r0 = riseCount;
        for (int f = 0; f < 5; f++) begin
            startOfFrame = 1'b1; tick(); startOfFrame = 1'b0; tick();
        end
        compared += 3;
        if (busy !== 1'b0)    begin mismatched++; $display("[TB] FAIL gap_drop_idle: got %b expected 0", busy); end
        if (busy2 !== 1'b0)   begin mismatched++; $display("[TB] FAIL gap_drop_idle_step40: got %b expected 0", busy2); end
        if (riseCount !== r0) begin mismatched++; $display("[TB] FAIL gap_drop_no_req: got %0d requests expected 0", riseCount - r0); end
        enable = 1'b1;
        repeat (2) tick();
        enable = 1'b0;
        repeat (6) tick();
        compared += 2;
        if (spawnValid !== 1'b0) begin mismatched++; $display("[TB] FAIL pipe_drop_no_offer: got %b expected 0", spawnValid); end
        if (busy !== 1'b0)       begin mismatched++; $display("[TB] FAIL pipe_drop_idle: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_offer();
        applyReset();
        startOffer(5, modelX(5, 24), modelX(5, 40), 1'b1);
        acceptOffer();
        startOffer(6, modelX(6, 24), modelX(6, 40), 1'b1);
        #2 resetN = 1'b0;
        #1;
        compared += 3;
        if (spawnValid !== 1'b0) begin mismatched++; $display("[TB] FAIL async_reset_valid: got %b expected 0", spawnValid); end
        if (spawnCount !== 8'd0) begin mismatched++; $display("[TB] FAIL async_reset_count: got %0d expected 0", spawnCount); end
        if (busy !== 1'b0)       begin mismatched++; $display("[TB] FAIL async_reset_busy: got %b expected 0", busy); end
        tick();
        resetN = 1'b1;
        expCount = 0;
        expQ.delete();
        exp2Q.delete();
    endtask

    task automatic test_back_to_back();
        int prev, r;
        applyReset();
        prev = -1;
        for (int n = 0; n < 6; n++) begin
            do r = int'($urandom_range(0, 31)); while (clampModel(r) == prev);
            startOffer(r, modelX(r, 24), modelX(r, 40), 1'b1);
            acceptOffer();
            prev = clampModel(r);
        end
        compared++;
        if (doubleRise !== 0) begin mismatched++; $display("[TB] FAIL rise_spacing: got %0d double-high cycles expected 0", doubleRise); end
    endtask

`ifdef NO_REPEAT_EN
    task automatic test_no_repeat();
        int r0;
        applyReset();
        startOffer(5, modelX(5, 24), modelX(5, 40), 1'b1);
        acceptOffer();
        r0 = riseCount;
        startOffer(5, modelX(6, 24), modelX(6, 40), 1'b1);
        compared++;
        if (riseCount - r0 !== 4) begin mismatched++; $display("[TB] FAIL retry_requests: got %0d expected 4", riseCount - r0); end
        acceptOffer();
        startOffer(12, modelX(12, 24), modelX(12, 40), 1'b1);
        acceptOffer();
        r0 = riseCount;
        startOffer(12, modelX(0, 24), modelX(0, 40), 1'b1);
        compared += 2;
        if (riseCount - r0 !== 4) begin mismatched++; $display("[TB] FAIL wrap_requests: got %0d expected 4", riseCount - r0); end
        if (doubleRise !== 0) begin mismatched++; $display("[TB] FAIL retry_spacing: got %0d double-high cycles expected 0", doubleRise); end
        acceptOffer();
    endtask
`endif

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_hold_and_gap();
        test_enable_drop();
        test_reset_mid_offer();
        test_back_to_back();
`ifdef NO_REPEAT_EN
        test_no_repeat();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
